// File: rtl/player_multishot_if.sv
// ---------------------------------------------------------------------------
// player_multishot_if
//   Signal bundle between the player controller and its neighbours (input
//   decode, collision logic, VGA colour mux).
//
//   Parameter
//     NUM_BULLETS   number of bullet slots; must match the controller
//
//   Signals
//     left, right      move requests (levels)
//     shoot            fire request (level, synchronised upstream)
//     bullet_hit       per-slot hit strobe from the collision logic
//     xPixel, yPixel   current raster position
//     player_x         cannon left edge
//     bullet_active    per-slot in-flight flag
//     bullet_x_flat    slot i x at [10*i +: 10]
//     bullet_y_flat    slot i y at [10*i +: 10]
//     fire_pulse       one-cycle strobe per accepted shot
//     player_color     RGB for the current pixel, 0 = transparent
//
//   Modports
//     master  drives the requests and raster position, observes the results
//     slave   the player controller
// ---------------------------------------------------------------------------
interface player_multishot_if #(
  parameter int NUM_BULLETS = 4
);
  logic                      left;
  logic                      right;
  logic                      shoot;
  logic [NUM_BULLETS-1:0]    bullet_hit;
  logic [9:0]                xPixel;
  logic [9:0]                yPixel;
  logic [9:0]                player_x;
  logic [NUM_BULLETS-1:0]    bullet_active;
  logic [10*NUM_BULLETS-1:0] bullet_x_flat;
  logic [10*NUM_BULLETS-1:0] bullet_y_flat;
  logic                      fire_pulse;
  logic [23:0]               player_color;

  modport master (
    output left, right, shoot, bullet_hit, xPixel, yPixel,
    input  player_x, bullet_active, bullet_x_flat, bullet_y_flat,
           fire_pulse, player_color
  );

  modport slave (
    input  left, right, shoot, bullet_hit, xPixel, yPixel,
    output player_x, bullet_active, bullet_x_flat, bullet_y_flat,
           fire_pulse, player_color
  );
endinterface

// File: rtl/player_multishot.sv
// ---------------------------------------------------------------------------
// player_multishot
//   Player cannon controller. The cannon moves horizontally on a slow move
//   tick and fires up to NUM_BULLETS concurrent shots that climb on a bullet
//   tick. Shots obey a cooldown counted in bullet ticks and retire on a hit
//   from the collision logic or on reaching the top of the screen. The block
//   also renders the cannon and its bullets for the current raster pixel.
//
//   Ports
//     clk   system clock
//     rst   synchronous reset, active low
//     bus   player_multishot_if.slave (requests, raster, bullets, colour)
//
//   Configuration
//     PLAYER_AUTOFIRE_EN  defined:   a held shoot level keeps requesting,
//                                    so shots repeat every COOLDOWN bullet
//                                    ticks while a slot is free
//                         undefined: only a rising edge of shoot requests
// ---------------------------------------------------------------------------
module player_multishot #(
  parameter int PLAYER_WIDTH  = 80,
  parameter int PLAYER_HEIGHT = 40,
  parameter int SCREEN_WIDTH  = 640,
  parameter int PLAYER_Y      = 400,
  parameter int START_X       = 280,
  parameter int MOVE_STEP     = 8,
  parameter int MOVE_DIV      = 5000000,
  parameter int BULLET_W      = 4,
  parameter int BULLET_H      = 12,
  parameter int BULLET_STEP   = 4,
  parameter int BULLET_DIV    = 1000000,
  parameter int NUM_BULLETS   = 4,
  parameter int COOLDOWN      = 8
) (
  input logic               clk,
  input logic               rst,
  player_multishot_if.slave bus
);

  localparam int MW = $clog2(MOVE_DIV);
  localparam int BW = $clog2(BULLET_DIV);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [9:0]  MAX_X    = 10'(SCREEN_WIDTH - PLAYER_WIDTH);
  localparam logic [9:0]  STEP_X   = 10'(MOVE_STEP);
  localparam logic [9:0]  STEP_Y   = 10'(BULLET_STEP);
  localparam logic [9:0]  SPAWN_DX = 10'(PLAYER_WIDTH / 2 - BULLET_W / 2);
  localparam logic [9:0]  SPAWN_Y  = 10'(PLAYER_Y - BULLET_H);
  localparam logic [10:0] PW11     = 11'(PLAYER_WIDTH);
  localparam logic [10:0] PY11     = 11'(PLAYER_Y);
  localparam logic [10:0] PH11     = 11'(PLAYER_HEIGHT);
  localparam logic [10:0] BW11     = 11'(BULLET_W);
  localparam logic [10:0] BH11     = 11'(BULLET_H);

  logic [MW-1:0]          move_cnt;
  logic [BW-1:0]          bullet_cnt;
  logic                   move_tick;
  logic                   bullet_tick;
  logic [9:0]             player_x_r;
  logic [9:0]             player_x_nx;
  logic                   shoot_q;
  logic [CW-1:0]          cooldown;
  logic                   fire_pulse_r;
  logic                   fire_req;
  logic                   accept;
  logic [NUM_BULLETS-1:0] active;
  logic [NUM_BULLETS-1:0] grant;
  logic [9:0]             bx [NUM_BULLETS];
  logic [9:0]             by [NUM_BULLETS];

  // ---------------- tick dividers ----------------
  assign move_tick   = (move_cnt == '0);
  assign bullet_tick = (bullet_cnt == '0);

  // NOTE: every register in always_ff uses <= so all state updates see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      move_cnt   <= MW'(MOVE_DIV - 1);
      bullet_cnt <= BW'(BULLET_DIV - 1);
    end else begin
      move_cnt   <= move_tick   ? MW'(MOVE_DIV - 1)   : move_cnt - MW'(1);
      bullet_cnt <= bullet_tick ? BW'(BULLET_DIV - 1) : bullet_cnt - BW'(1);
    end
  end

  // ---------------- cannon movement ----------------
  // NOTE: the default assignment first means every path writes player_x_nx,
  // so no latch is inferred.
  always_comb begin
    player_x_nx = player_x_r;
    if (move_tick && bus.left && !bus.right) begin
      player_x_nx = (player_x_r < STEP_X) ? '0 : player_x_r - STEP_X;
    end else if (move_tick && bus.right && !bus.left) begin
      player_x_nx = (player_x_r > MAX_X - STEP_X) ? MAX_X : player_x_r + STEP_X;
    end
  end

  // ---------------- fire request / slot allocation ----------------
`ifdef PLAYER_AUTOFIRE_EN
  assign fire_req = bus.shoot;
`else
  assign fire_req = bus.shoot && !shoot_q;
`endif

  // Lowest clear bit of active, one-hot; zero when every slot is busy
  // because the increment wraps to zero.
  assign grant  = ~active & (active + NUM_BULLETS'(1));
  assign accept = fire_req && (cooldown == '0) && (grant != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      player_x_r   <= 10'(START_X);
      shoot_q      <= 1'b0;
      cooldown     <= '0;
      fire_pulse_r <= 1'b0;
    end else begin
      player_x_r   <= player_x_nx;
      shoot_q      <= bus.shoot;
      fire_pulse_r <= accept;
      if (accept) begin
        cooldown <= CW'(COOLDOWN);
      end else if (bullet_tick && cooldown != '0) begin
        cooldown <= cooldown - CW'(1);
      end
    end
  end

  // ---------------- bullet slots ----------------
  // A granted slot is always inactive, so the spawn branch never competes
  // with the flight rules; a slot freed this cycle shows as busy in grant
  // until the next cycle.
  // NOTE: the slot arrays are reset explicitly because consumers read their
  // coordinates directly; a few registers, not a RAM, so the reset is cheap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (accept && grant[i]) begin
          active[i] <= 1'b1;
          bx[i]     <= player_x_r + SPAWN_DX;
          by[i]     <= SPAWN_Y;
        end else if (active[i]) begin
          if (bus.bullet_hit[i]) begin
            active[i] <= 1'b0;
            bx[i]     <= '0;
            by[i]     <= '0;
          end else if (bullet_tick) begin
            // Retire before subtracting so y never wraps below zero.
            if (by[i] < STEP_Y) active[i] <= 1'b0;
            else                by[i]     <= by[i] - STEP_Y;
          end
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.player_x      = player_x_r;
  assign bus.bullet_active = active;
  assign bus.fire_pulse    = fire_pulse_r;

  always_comb begin
    bus.bullet_x_flat = '0;
    bus.bullet_y_flat = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bus.bullet_x_flat[10*i +: 10] = bx[i];
      bus.bullet_y_flat[10*i +: 10] = by[i];
    end
  end

  // Half-open boxes evaluated in 11 bits so x+W never wraps. Bullets are
  // painted first and the cannon overrides them.
  always_comb begin
    logic [10:0] px;
    logic [10:0] py;
    px = {1'b0, bus.xPixel};
    py = {1'b0, bus.yPixel};
    bus.player_color = 24'h000000;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active[i] &&
          px >= {1'b0, bx[i]} && px < {1'b0, bx[i]} + BW11 &&
          py >= {1'b0, by[i]} && py < {1'b0, by[i]} + BH11) begin
        bus.player_color = 24'hFF0000;
      end
    end
    if (px >= {1'b0, player_x_r} && px < {1'b0, player_x_r} + PW11 &&
        py >= PY11 && py < PY11 + PH11) begin
      bus.player_color = 24'h00FF19;
    end
  end

endmodule

// File: tb/tb_player_multishot.sv
// ---------------------------------------------------------------------------
// tb_player_multishot
//   Randomised bench for player_multishot with MOVE_DIV=4, BULLET_DIV=2,
//   COOLDOWN=2, NUM_BULLETS=2. A behavioural model counts cycles since reset
//   to place the ticks and applies the movement, firing and flight rules with
//   plain integer arithmetic; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_player_multishot;

  localparam int NB      = 2;
  localparam int MDIV    = 4;
  localparam int BDIV    = 2;
  localparam int CD      = 2;
  localparam int START   = 280;
  localparam int MAXX    = 640 - 80;
  localparam int NCYCLES = 2800;

  logic clk;
  logic rst;

  player_multishot_if #(.NUM_BULLETS(NB)) bus ();

  player_multishot #(
    .MOVE_DIV    (MDIV),
    .BULLET_DIV  (BDIV),
    .COOLDOWN    (CD),
    .NUM_BULLETS (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x;
  int m_cd;
  int m_n;        // clocks with rst high since the last reset
  bit m_sq;
  bit m_fp;
  bit m_act   [NB];
  bit m_known [NB];  // coordinates are defined while inactive (reset / hit)
  int m_bx    [NB];
  int m_by    [NB];

  task automatic model_step();
    bit req;
    bit acc;
    bit mt;
    bit bt;
    int g;
    if (!rst) begin
      m_x = START; m_cd = 0; m_n = 0; m_sq = 0; m_fp = 0;
      for (int i = 0; i < NB; i++) begin
        m_act[i] = 0; m_known[i] = 1; m_bx[i] = 0; m_by[i] = 0;
      end
      return;
    end
    mt = (m_n % MDIV) == MDIV - 1;
    bt = (m_n % BDIV) == BDIV - 1;
`ifdef PLAYER_AUTOFIRE_EN
    req = bus.shoot;
`else
    req = bus.shoot && !m_sq;
`endif
    g = -1;
    for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) g = i;
    acc = req && (m_cd == 0) && (g >= 0);
    for (int i = 0; i < NB; i++) begin
      if (acc && i == g) begin
        m_act[i] = 1; m_bx[i] = m_x + 40 - 2; m_by[i] = 400 - 12;
      end else if (m_act[i]) begin
        if (bus.bullet_hit[i]) begin
          m_act[i] = 0; m_bx[i] = 0; m_by[i] = 0; m_known[i] = 1;
        end else if (bt) begin
          if (m_by[i] < 4) begin
            m_act[i] = 0; m_known[i] = 0;
          end else begin
            m_by[i] -= 4;
          end
        end
      end
    end
    if (acc)                m_cd = CD;
    else if (bt && m_cd > 0) m_cd--;
    m_fp = acc;
    m_sq = bus.shoot;
    if (mt) begin
      if (bus.left && !bus.right)      m_x = (m_x - 8 < 0) ? 0 : m_x - 8;
      else if (bus.right && !bus.left) m_x = (m_x + 8 > MAXX) ? MAXX : m_x + 8;
    end
    m_n++;
  endtask

  function automatic logic [23:0] model_color(int px, int py);
    if (px >= m_x && px < m_x + 80 && py >= 400 && py < 440) return 24'h00FF19;
    for (int i = 0; i < NB; i++)
      if (m_act[i] && px >= m_bx[i] && px < m_bx[i] + 4 &&
          py >= m_by[i] && py < m_by[i] + 12) return 24'hFF0000;
    return 24'h000000;
  endfunction

  task automatic check_state();
    logic [NB-1:0] exp_act;
    for (int i = 0; i < NB; i++) exp_act[i] = m_act[i];
    check("player_x", 64'(bus.player_x), 64'(m_x));
    check("bullet_active", 64'(bus.bullet_active), 64'(exp_act));
    check("fire_pulse", 64'(bus.fire_pulse), 64'(m_fp));
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] || m_known[i]) begin
        check($sformatf("bullet_x[%0d]", i), 64'(bus.bullet_x_flat[10*i +: 10]), 64'(m_bx[i]));
        check($sformatf("bullet_y[%0d]", i), 64'(bus.bullet_y_flat[10*i +: 10]), 64'(m_by[i]));
      end
    end
  endtask

  task automatic set_pixel(input int px, input int py);
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    bus.xPixel = 10'(px & 1023);
    bus.yPixel = 10'(py & 1023);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int phase;
    int sel;
    int k;
    rst = 1'b0;
    bus.left = 0; bus.right = 0; bus.shoot = 0; bus.bullet_hit = '0;
    bus.xPixel = '0; bus.yPixel = '0;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end

    // Reset values, then released.
    @(negedge clk);
    rst = 1'b1;
    check("reset_player_x", 64'(bus.player_x), 64'(START));
    check("reset_active", 64'(bus.bullet_active), 64'(0));
    check("reset_fire_pulse", 64'(bus.fire_pulse), 64'(0));
    set_pixel(300, 410);
    #1 check("reset_color_cannon", 64'(bus.player_color), 64'(24'h00FF19));
    set_pixel(0, 0);
    #1 check("reset_color_blank", 64'(bus.player_color), 64'(24'h000000));
    @(posedge clk);
    model_step();

    for (int cyc = 0; cyc < NCYCLES; cyc++) begin
      @(negedge clk);
      check_state();

      phase = cyc / 400;
      rst   = ($urandom_range(0, 499) != 0);
      case (phase)
        0, 4:    begin bus.right = ($urandom_range(0, 9) != 0); bus.left = ($urandom_range(0, 9) == 0); end
        1, 5:    begin bus.left = ($urandom_range(0, 9) != 0); bus.right = ($urandom_range(0, 9) == 0); end
        2:       begin bus.left = 1; bus.right = 1; end
        default: begin bus.left = $urandom_range(0, 1); bus.right = $urandom_range(0, 1); end
      endcase
      // Occasionally hold shoot for long stretches, otherwise toggle freely.
      if (phase == 3) bus.shoot = ((cyc % 40) < 20);
      else            bus.shoot = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NB; i++) bus.bullet_hit[i] = ($urandom_range(0, 24) == 0);

      sel = $urandom_range(0, 2);
      k   = $urandom_range(0, NB - 1);
      if (sel == 0)
        set_pixel($urandom_range(0, 639), $urandom_range(0, 479));
      else if (sel == 1)
        set_pixel(m_x - 3 + $urandom_range(0, 86), 397 + $urandom_range(0, 46));
      else
        set_pixel(m_bx[k] - 2 + $urandom_range(0, 7), m_by[k] - 2 + $urandom_range(0, 15));
      #1 check("player_color", 64'(bus.player_color),
               64'(model_color(int'(bus.xPixel), int'(bus.yPixel))));

      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    check_state();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
